// File: rtl/regarb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Used by the interface, the scoreboard and the arbiter top.
package regarb_pkg;

    localparam int ADDR_W = 3;
    localparam int NUM_REGS = 8;
    localparam int CNT_W = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;
    localparam logic WS_ALU = 1'b0;
    localparam logic WS_LD = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LD
    } gnt_e;

endpackage

// File: rtl/regbank_wr_arbiter_if.sv
// Request/grant, scoreboard and bank-control signals of the write arbiter.
// master = issue/decode/writeback side, slave = arbiter.
interface regbank_wr_arbiter_if;
    import regarb_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic              alu_ready;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_addr;
    logic              ld_issue_rdy;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_ready;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic              rd_stall;
    logic [ADDR_W-1:0] Wa;
    logic              Wen;
    logic              WS;

    modport master (
        output alu_valid, alu_addr,
        output ld_issue, ld_issue_addr,
        output ld_valid, ld_addr,
        output rd1_addr, rd2_addr,
        input  alu_ready, ld_issue_rdy, ld_ready,
        input  rd_stall, Wa, Wen, WS
    );

    modport slave (
        input  alu_valid, alu_addr,
        input  ld_issue, ld_issue_addr,
        input  ld_valid, ld_addr,
        input  rd1_addr, rd2_addr,
        output alu_ready, ld_issue_rdy, ld_ready,
        output rd_stall, Wa, Wen, WS
    );

endinterface

// File: rtl/regarb_scoreboard.sv
// Load-in-flight scoreboard: per-register busy bits and outstanding count.
// Produces the load-issue permit and the read-hazard stall.
module regarb_scoreboard
    import regarb_pkg::*;
#(
    parameter int LD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_addr,
    input  logic              ld_gnt,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              ld_issue_rdy,
    output logic              rd_stall
);

    logic [NUM_REGS-1:0] busy, busy_nxt;
    logic [CNT_W-1:0]    outstanding, out_nxt;
    logic                issue_ok, dec, full, dest_busy;
    logic                rd1_hz, rd2_hz;

    assign full      = (outstanding == CNT_W'(LD_MAX));
    assign dest_busy = (ld_issue_addr != REG_ZERO) && busy[ld_issue_addr];
    assign ld_issue_rdy = !full && !dest_busy;
    assign issue_ok  = ld_issue && ld_issue_rdy;
    assign dec       = ld_gnt && (outstanding != '0);

    assign rd1_hz   = (rd1_addr != REG_ZERO) && busy[rd1_addr];
    assign rd2_hz   = (rd2_addr != REG_ZERO) && busy[rd2_addr];
    assign rd_stall = rd1_hz || rd2_hz;

    // Issue is applied after the grant clear so a same-register pair ends busy.
    always_comb begin
        busy_nxt = busy;
        if (ld_gnt)
            busy_nxt[ld_addr] = 1'b0;
        if (issue_ok && (ld_issue_addr != REG_ZERO))
            busy_nxt[ld_issue_addr] = 1'b1;
    end

    always_comb begin
        out_nxt = outstanding;
        unique case (1'b1)
            issue_ok && !dec: out_nxt = outstanding + 1'b1;
            dec && !issue_ok: out_nxt = outstanding - 1'b1;
            default:          out_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy        <= busy_nxt;
            outstanding <= out_nxt;
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Write-port arbiter for the 8x16 bank: ALU vs load writeback, plus hazards.
// Starvation guard built only when REGARB_STARVE_EN is defined.
module regbank_wr_arbiter
    import regarb_pkg::*;
#(
    parameter int LD_MAX     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regbank_wr_arbiter_if.slave  bus
);

    if (LD_MAX < 1 || LD_MAX > 8) begin : g_ld_chk
        $error("LD_MAX out of range");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_st_chk
        $error("STARVE_MAX out of range");
    end

    gnt_e gnt;
    logic force_alu, ld_win, alu_win;

`ifdef REGARB_STARVE_EN
    logic [CNT_W-1:0] starve_cnt;

    assign force_alu = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!bus.alu_valid || gnt == GNT_ALU)
            starve_cnt <= '0;
        else if (gnt == GNT_LD && !force_alu)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_alu = 1'b0;
`endif

    assign ld_win  = bus.ld_valid && !(bus.alu_valid && force_alu);
    assign alu_win = bus.alu_valid && !ld_win;

    always_comb begin
        gnt = GNT_NONE;
        unique case (1'b1)
            ld_win:  gnt = GNT_LD;
            alu_win: gnt = GNT_ALU;
            default: gnt = GNT_NONE;
        endcase
    end

    always_comb begin
        bus.alu_ready = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.Wa        = REG_ZERO;
        bus.WS        = WS_ALU;
        unique case (gnt)
            GNT_ALU: begin
                bus.alu_ready = 1'b1;
                bus.Wa        = bus.alu_addr;
            end
            GNT_LD: begin
                bus.ld_ready = 1'b1;
                bus.Wa       = bus.ld_addr;
                bus.WS       = WS_LD;
            end
            default: ;
        endcase
    end

    // r0 requests still complete; only the bank write is suppressed.
    assign bus.Wen = (gnt != GNT_NONE) && (bus.Wa != REG_ZERO);

    regarb_scoreboard #(
        .LD_MAX (LD_MAX)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_issue      (bus.ld_issue),
        .ld_issue_addr (bus.ld_issue_addr),
        .ld_gnt        (gnt == GNT_LD),
        .ld_addr       (bus.ld_addr),
        .rd1_addr      (bus.rd1_addr),
        .rd2_addr      (bus.rd2_addr),
        .ld_issue_rdy  (bus.ld_issue_rdy),
        .rd_stall      (bus.rd_stall)
    );

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter (LD_MAX=4, STARVE_MAX=3).
// Grant-pattern expectations follow REGARB_STARVE_EN.
module tb_regbank_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    regbank_wr_arbiter_if bus ();

    regbank_wr_arbiter #(
        .LD_MAX     (4),
        .STARVE_MAX (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid     = 1'b0;
        bus.alu_addr      = 3'd0;
        bus.ld_issue      = 1'b0;
        bus.ld_issue_addr = 3'd0;
        bus.ld_valid      = 1'b0;
        bus.ld_addr       = 3'd0;
        bus.rd1_addr      = 3'd0;
        bus.rd2_addr      = 3'd0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [4:0] exp_ld;

    initial begin
`ifdef REGARB_STARVE_EN
        exp_ld = 5'b10111;
`else
        exp_ld = 5'b11111;
`endif
        idle();
        #2;
        chk("rst_wen", 8'(bus.Wen), 8'd0);
        chk("rst_ws", 8'(bus.WS), 8'd0);
        chk("rst_wa", 8'(bus.Wa), 8'd0);
        chk("rst_alu_rdy", 8'(bus.alu_ready), 8'd0);
        chk("rst_ld_rdy", 8'(bus.ld_ready), 8'd0);
        chk("rst_stall", 8'(bus.rd_stall), 8'd0);
        chk("rst_issue_rdy", 8'(bus.ld_issue_rdy), 8'd1);
        cyc();
        rst_n = 1'b1;

        // 1: uncontended ALU write
        cyc();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 3'd3;
        #1;
        chk("t1_alu_rdy", 8'(bus.alu_ready), 8'd1);
        chk("t1_wen", 8'(bus.Wen), 8'd1);
        chk("t1_ws", 8'(bus.WS), 8'd0);
        chk("t1_wa", 8'(bus.Wa), 8'd3);
        chk("t1_ld_rdy", 8'(bus.ld_ready), 8'd0);
        cyc();
        idle();

        // 2: contention for 5 cycles
        cyc();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 3'd2;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 3'd6;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t2_ld_rdy%0d", i), 8'(bus.ld_ready), 8'(exp_ld[i]));
            chk($sformatf("t2_alu_rdy%0d", i), 8'(bus.alu_ready), 8'(!exp_ld[i]));
            chk($sformatf("t2_ws%0d", i), 8'(bus.WS), 8'(exp_ld[i]));
            chk($sformatf("t2_wa%0d", i), 8'(bus.Wa), exp_ld[i] ? 8'd6 : 8'd2);
            cyc();
        end
        idle();

        // 3: load hazard on r5
        cyc();
        bus.ld_issue      = 1'b1;
        bus.ld_issue_addr = 3'd5;
        #1;
        chk("t3_issue_rdy", 8'(bus.ld_issue_rdy), 8'd1);
        cyc();
        bus.ld_issue = 1'b0;
        bus.rd1_addr = 3'd5;
        #1;
        chk("t3_stall", 8'(bus.rd_stall), 8'd1);
        chk("t3_issue_busy", 8'(bus.ld_issue_rdy), 8'd0);
        cyc();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd5;
        #1;
        chk("t3_ld_rdy", 8'(bus.ld_ready), 8'd1);
        chk("t3_wa", 8'(bus.Wa), 8'd5);
        chk("t3_ws", 8'(bus.WS), 8'd1);
        chk("t3_wen", 8'(bus.Wen), 8'd1);
        chk("t3_stall_hold", 8'(bus.rd_stall), 8'd1);
        cyc();
        bus.ld_valid = 1'b0;
        #1;
        chk("t3_stall_clr", 8'(bus.rd_stall), 8'd0);
        chk("t3_issue_rdy2", 8'(bus.ld_issue_rdy), 8'd1);
        cyc();
        idle();

        // 4: outstanding limit
        for (int i = 1; i <= 4; i++) begin
            cyc();
            bus.ld_issue      = 1'b1;
            bus.ld_issue_addr = 3'(i);
            #1;
            chk($sformatf("t4_issue%0d", i), 8'(bus.ld_issue_rdy), 8'd1);
        end
        cyc();
        bus.ld_issue_addr = 3'd6;
        #1;
        chk("t4_full", 8'(bus.ld_issue_rdy), 8'd0);
        cyc();
        bus.ld_issue = 1'b0;
        bus.rd1_addr = 3'd6;
        bus.rd2_addr = 3'd4;
        #1;
        chk("t4_stall_r4", 8'(bus.rd_stall), 8'd1);
        bus.rd2_addr = 3'd0;
        #1;
        chk("t4_ignored", 8'(bus.rd_stall), 8'd0);
        chk("t4_still_full", 8'(bus.ld_issue_rdy), 8'd0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd1;
        #1;
        chk("t4_grant_r1", 8'(bus.ld_ready), 8'd1);
        cyc();
        bus.ld_valid = 1'b0;
        #1;
        chk("t4_rdy_after", 8'(bus.ld_issue_rdy), 8'd1);
        cyc();
        bus.ld_issue      = 1'b1;
        bus.ld_issue_addr = 3'd6;
        bus.ld_valid      = 1'b1;
        bus.ld_addr       = 3'd2;
        #1;
        chk("t4_both_rdy", 8'(bus.ld_issue_rdy), 8'd1);
        chk("t4_both_grant", 8'(bus.ld_ready), 8'd1);
        cyc();
        bus.ld_valid      = 1'b0;
        bus.ld_issue      = 1'b0;
        bus.ld_issue_addr = 3'd7;
        bus.rd1_addr      = 3'd6;
        bus.rd2_addr      = 3'd2;
        #1;
        chk("t4_cnt3", 8'(bus.ld_issue_rdy), 8'd1);
        chk("t4_r6_busy", 8'(bus.rd_stall), 8'd1);
        bus.rd1_addr = 3'd0;
        #1;
        chk("t4_r2_free", 8'(bus.rd_stall), 8'd0);
        bus.ld_issue = 1'b1;
        cyc();
        bus.ld_issue      = 1'b0;
        bus.ld_issue_addr = 3'd0;
        #1;
        chk("t4_cnt4", 8'(bus.ld_issue_rdy), 8'd0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd3;
        cyc();
        bus.ld_addr = 3'd4;
        cyc();
        bus.ld_addr = 3'd6;
        cyc();
        bus.ld_addr = 3'd7;
        cyc();
        idle();
        bus.rd1_addr = 3'd7;
        bus.rd2_addr = 3'd6;
        #1;
        chk("t4_drained", 8'(bus.rd_stall), 8'd0);
        chk("t4_drained_rdy", 8'(bus.ld_issue_rdy), 8'd1);
        cyc();
        idle();

        // 5: writes and loads targeting r0
        cyc();
        bus.alu_valid = 1'b1;
        bus.alu_addr  = 3'd0;
        #1;
        chk("t5_alu_rdy", 8'(bus.alu_ready), 8'd1);
        chk("t5_wen", 8'(bus.Wen), 8'd0);
        cyc();
        idle();
        bus.ld_issue = 1'b1;
        #1;
        chk("t5_issue_r0", 8'(bus.ld_issue_rdy), 8'd1);
        cyc();
        bus.ld_issue = 1'b0;
        #1;
        chk("t5_no_stall", 8'(bus.rd_stall), 8'd0);
        chk("t5_r0_rdy", 8'(bus.ld_issue_rdy), 8'd1);
        bus.ld_valid = 1'b1;
        #1;
        chk("t5_ld_r0", 8'(bus.ld_ready), 8'd1);
        chk("t5_ld_wen", 8'(bus.Wen), 8'd0);
        chk("t5_ld_ws", 8'(bus.WS), 8'd1);
        cyc();
        idle();

        // 6: asynchronous reset with loads pending
        cyc();
        bus.ld_issue      = 1'b1;
        bus.ld_issue_addr = 3'd1;
        cyc();
        bus.ld_issue_addr = 3'd2;
        cyc();
        bus.ld_issue      = 1'b0;
        bus.ld_issue_addr = 3'd1;
        bus.rd1_addr      = 3'd1;
        bus.rd2_addr      = 3'd2;
        #1;
        chk("t6_stall", 8'(bus.rd_stall), 8'd1);
        chk("t6_busy", 8'(bus.ld_issue_rdy), 8'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stall", 8'(bus.rd_stall), 8'd0);
        chk("t6_rst_rdy", 8'(bus.ld_issue_rdy), 8'd1);
        chk("t6_rst_wen", 8'(bus.Wen), 8'd0);
        chk("t6_rst_wa", 8'(bus.Wa), 8'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        chk("t6_post_stall", 8'(bus.rd_stall), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
